// File: rtl/if_stage.sv
// Instruction fetch stage: owns the PC and issues one-word reads to instruction
// memory with at most one request outstanding. It hands the PC/RVFI context of
// each request to decode, and it handles redirects from execute, including
// redirects that arrive while a request is in flight.
// Optional feature macro: IF_MISALIGN_TRAP_EN (trap on misaligned redirect).

package if_stage_pkg;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc_rdata;
        logic [31:0] pc_wdata;
    } rvfi_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] pc_next;
        rvfi_t       rvfi;
    } if_stage_t;

endpackage

module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h1eceb000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc,
    input  logic        id_stall,
    input  logic        load_hazard,
    output logic [31:0] imem_addr,
    output logic [3:0]  imem_rmask,
    input  logic        imem_resp,
    output logic        o_fetch_flush,
`ifdef IF_MISALIGN_TRAP_EN
    output logic        o_misaligned,
`endif
    output if_stage_t   if_stage_reg
);

    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {
        START   = 2'd0,
        BUSY    = 2'd1,
        HOLD    = 2'd2,
        DISCARD = 2'd3
    } state_t;

    state_t            state;
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   saved_pc;
    logic [XLEN-1:0]   pc_inc;
    logic [XLEN-1:0]   redir_pc;
    logic [XLEN-1:0]   issue_addr;
    logic              issue;
    logic              flush;
    logic              stall;

    assign stall  = id_stall | load_hazard;
    assign pc_inc = XLEN'(pc + 32'd4);

`ifdef IF_MISALIGN_TRAP_EN
    logic misaligned;
    logic mis_redirect;

    // Redirect targets pass unchanged; a misaligned one halts fetch.
    assign redir_pc      = i_redirect_pc;
    assign mis_redirect  = i_redirect & (i_redirect_pc[1:0] != 2'b00);
    assign o_misaligned  = misaligned;
`else
    logic unused_redir_lsbs;

    // Without the trap, redirect targets are word-aligned by dropping the low bits.
    assign redir_pc          = {i_redirect_pc[31:2], 2'b00};
    assign unused_redir_lsbs = ^i_redirect_pc[1:0];
`endif

    // Decide whether this cycle issues a request, and at which address.
    always_comb begin
        issue      = 1'b0;
        issue_addr = saved_pc;
        flush      = 1'b0;
        case (state)
            START: begin
                issue = 1'b1;
            end
            BUSY: begin
                issue_addr = i_redirect ? redir_pc : pc_inc;
                issue      = imem_resp & ~stall;
            end
            HOLD: begin
                issue_addr = i_redirect ? redir_pc : saved_pc;
                issue      = ~stall;
            end
            DISCARD: begin
                issue_addr = i_redirect ? redir_pc : saved_pc;
                if (imem_resp) begin
                    flush = 1'b1;
                    issue = ~stall;
                end
            end
            default: begin
                issue = 1'b0;
            end
        endcase
`ifdef IF_MISALIGN_TRAP_EN
        if (misaligned | mis_redirect) begin
            issue = 1'b0;
        end
`endif
        if (rst) begin
            issue      = 1'b0;
            issue_addr = RESET_PC;
            flush      = 1'b0;
        end
    end

    assign imem_addr     = issue_addr;
    assign imem_rmask    = issue ? 4'hF : 4'h0;
    assign o_fetch_flush = flush;

    // Fetch state machine, PC tracking and decode-facing pipeline register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= START;
            pc           <= '0;
            saved_pc     <= RESET_PC;
            if_stage_reg <= '0;
`ifdef IF_MISALIGN_TRAP_EN
            misaligned   <= 1'b0;
`endif
        end else begin
            if (issue) begin
                pc                         <= issue_addr;
                if_stage_reg.pc            <= issue_addr;
                if_stage_reg.pc_next       <= XLEN'(issue_addr + 32'd4);
                if_stage_reg.rvfi.valid    <= 1'b1;
                if_stage_reg.rvfi.pc_rdata <= issue_addr;
                if_stage_reg.rvfi.pc_wdata <= XLEN'(issue_addr + 32'd4);
                state                      <= BUSY;
            end else begin
                case (state)
                    BUSY: begin
                        if (imem_resp) begin
                            saved_pc <= issue_addr;
                            state    <= HOLD;
                        end else if (i_redirect) begin
                            saved_pc                <= issue_addr;
                            state                   <= DISCARD;
                            if_stage_reg.rvfi.valid <= 1'b0;
                        end
                    end
                    HOLD: begin
                        saved_pc <= issue_addr;
                    end
                    DISCARD: begin
                        saved_pc <= issue_addr;
                        if (imem_resp) begin
                            state <= HOLD;
                        end
                    end
                    default: begin
                        state <= state;
                    end
                endcase
            end
`ifdef IF_MISALIGN_TRAP_EN
            if (mis_redirect) begin
                misaligned              <= 1'b1;
                state                   <= HOLD;
                if_stage_reg.rvfi.valid <= 1'b0;
            end
`endif
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: expected request addresses are queued per
// scenario and popped as the DUT raises imem_rmask.
module tb_if_stage;
    import if_stage_pkg::*;

    localparam logic [31:0] RST_PC = 32'h1eceb000;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_redirect;
    logic [31:0] i_redirect_pc;
    logic        id_stall;
    logic        load_hazard;
    logic [31:0] imem_addr;
    logic [3:0]  imem_rmask;
    logic        imem_resp;
    logic        o_fetch_flush;
`ifdef IF_MISALIGN_TRAP_EN
    logic        o_misaligned;
`endif
    if_stage_t   if_stage_reg;

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] exp_q[$];

    if_stage #(.RESET_PC(RST_PC)) dut (
        .clk           (clk),
        .rst           (rst),
        .i_redirect    (i_redirect),
        .i_redirect_pc (i_redirect_pc),
        .id_stall      (id_stall),
        .load_hazard   (load_hazard),
        .imem_addr     (imem_addr),
        .imem_rmask    (imem_rmask),
        .imem_resp     (imem_resp),
        .o_fetch_flush (o_fetch_flush),
`ifdef IF_MISALIGN_TRAP_EN
        .o_misaligned  (o_misaligned),
`endif
        .if_stage_reg  (if_stage_reg)
    );

    always #5 clk = ~clk;

    // One cycle: drive inputs, check request/flush at negedge, pop scoreboard.
    task automatic tick(input logic redir, input logic [31:0] rpc, input logic [1:0] st,
                        input logic rsp, input logic req, input logic fl, input string name);
        logic [31:0] exp_addr;
        logic [3:0]  exp_mask;
        i_redirect    = redir;
        i_redirect_pc = rpc;
        id_stall      = st[0];
        load_hazard   = st[1];
        imem_resp     = rsp;
        exp_mask      = req ? 4'hF : 4'h0;
        @(negedge clk);
        checks++;
        if (imem_rmask !== exp_mask) begin
            failures++;
            $display("FAIL %s rmask got=%h want=%h", name, imem_rmask, exp_mask);
        end
        checks++;
        if (o_fetch_flush !== fl) begin
            failures++;
            $display("FAIL %s fetch_flush got=%b want=%b", name, o_fetch_flush, fl);
        end
        if (imem_rmask === 4'hF) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL %s unexpected request got=%h want=none", name, imem_addr);
            end else begin
                exp_addr = exp_q.pop_front();
                if (imem_addr !== exp_addr) begin
                    failures++;
                    $display("FAIL %s addr got=%h want=%h", name, imem_addr, exp_addr);
                end
            end
        end
        @(posedge clk);
        #1;
        i_redirect  = 1'b0;
        id_stall    = 1'b0;
        load_hazard = 1'b0;
        imem_resp   = 1'b0;
    endtask

    task automatic apply_reset();
        rst           = 1'b1;
        i_redirect    = 1'b0;
        i_redirect_pc = '0;
        id_stall      = 1'b0;
        load_hazard   = 1'b0;
        imem_resp     = 1'b0;
        exp_q.delete();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic end_queue(input string name);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL %s missing requests got=%0d want=0", name, exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic test_reset();
        rst           = 1'b1;
        i_redirect    = 1'b0;
        i_redirect_pc = '0;
        id_stall      = 1'b0;
        load_hazard   = 1'b0;
        imem_resp     = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        checks++;
        if (imem_rmask !== 4'h0) begin
            failures++;
            $display("FAIL reset_rmask got=%h want=0", imem_rmask);
        end
        checks++;
        if (imem_addr !== RST_PC) begin
            failures++;
            $display("FAIL reset_addr got=%h want=%h", imem_addr, RST_PC);
        end
        checks++;
        if (o_fetch_flush !== 1'b0) begin
            failures++;
            $display("FAIL reset_flush got=%b want=0", o_fetch_flush);
        end
        checks++;
        if (if_stage_reg !== '0) begin
            failures++;
            $display("FAIL reset_reg got=%h want=0", if_stage_reg);
        end
`ifdef IF_MISALIGN_TRAP_EN
        checks++;
        if (o_misaligned !== 1'b0) begin
            failures++;
            $display("FAIL reset_misaligned got=%b want=0", o_misaligned);
        end
`endif
        imem_resp = 1'b0;
        rst       = 1'b0;
    endtask

    task automatic test_back_to_back();
        apply_reset();
        for (int i = 0; i < 4; i++) exp_q.push_back(RST_PC + 32'(4 * i));
        tick(1'b0, '0, 2'b00, 1'b0, 1'b1, 1'b0, "b2b_first");
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (if_stage_reg.pc !== RST_PC + 32'(4 * i) || if_stage_reg.rvfi.valid !== 1'b1) begin
                failures++;
                $display("FAIL b2b_reg%0d got pc=%h valid=%b want pc=%h valid=1", i,
                         if_stage_reg.pc, if_stage_reg.rvfi.valid, RST_PC + 32'(4 * i));
            end
            tick(1'b0, '0, 2'b00, 1'b1, 1'b1, 1'b0, "b2b_resp");
        end
        checks++;
        if (if_stage_reg.pc_next !== RST_PC + 32'd16 || if_stage_reg.rvfi.pc_rdata !== RST_PC + 32'd12
            || if_stage_reg.rvfi.pc_wdata !== RST_PC + 32'd16) begin
            failures++;
            $display("FAIL b2b_rvfi got next=%h rdata=%h wdata=%h want %h %h %h",
                     if_stage_reg.pc_next, if_stage_reg.rvfi.pc_rdata, if_stage_reg.rvfi.pc_wdata,
                     RST_PC + 32'd16, RST_PC + 32'd12, RST_PC + 32'd16);
        end
        end_queue("b2b_queue");
    endtask

    task automatic test_stall();
        apply_reset();
        exp_q.push_back(RST_PC);
        exp_q.push_back(RST_PC + 32'd4);
        exp_q.push_back(RST_PC + 32'd8);
        exp_q.push_back(RST_PC + 32'd12);
        tick(1'b0, '0, 2'b00, 1'b0, 1'b1, 1'b0, "stall_c0");
        tick(1'b0, '0, 2'b00, 1'b1, 1'b1, 1'b0, "stall_c1");
        tick(1'b0, '0, 2'b01, 1'b1, 1'b0, 1'b0, "stall_resp");
        checks++;
        if (if_stage_reg.pc !== RST_PC + 32'd4) begin
            failures++;
            $display("FAIL stall_reg got=%h want=%h", if_stage_reg.pc, RST_PC + 32'd4);
        end
        tick(1'b0, '0, 2'b01, 1'b0, 1'b0, 1'b0, "stall_c3");
        tick(1'b0, '0, 2'b01, 1'b0, 1'b0, 1'b0, "stall_c4");
        tick(1'b0, '0, 2'b00, 1'b0, 1'b1, 1'b0, "stall_release");
        tick(1'b0, '0, 2'b10, 1'b1, 1'b0, 1'b0, "hazard_resp");
        tick(1'b0, '0, 2'b00, 1'b0, 1'b1, 1'b0, "hazard_release");
        end_queue("stall_queue");
    endtask

    task automatic test_redirect_resp();
        apply_reset();
        exp_q.push_back(RST_PC);
        exp_q.push_back(32'h1eceb100);
        exp_q.push_back(32'h1eceb104);
        tick(1'b0, '0, 2'b00, 1'b0, 1'b1, 1'b0, "rr_c0");
        tick(1'b1, 32'h1eceb100, 2'b00, 1'b1, 1'b1, 1'b0, "rr_redirect");
        checks++;
        if (if_stage_reg.pc !== 32'h1eceb100 || if_stage_reg.rvfi.valid !== 1'b1) begin
            failures++;
            $display("FAIL rr_reg got pc=%h valid=%b want pc=1eceb100 valid=1",
                     if_stage_reg.pc, if_stage_reg.rvfi.valid);
        end
        tick(1'b0, '0, 2'b00, 1'b1, 1'b1, 1'b0, "rr_next");
        end_queue("rr_queue");
    endtask

    task automatic test_discard();
        apply_reset();
        exp_q.push_back(RST_PC);
        exp_q.push_back(RST_PC + 32'd4);
        exp_q.push_back(32'h1eceb200);
        exp_q.push_back(32'h1eceb204);
        tick(1'b0, '0, 2'b00, 1'b0, 1'b1, 1'b0, "disc_c0");
        tick(1'b0, '0, 2'b00, 1'b1, 1'b1, 1'b0, "disc_c1");
        tick(1'b1, 32'h1eceb200, 2'b00, 1'b0, 1'b0, 1'b0, "disc_redirect");
        checks++;
        if (if_stage_reg.rvfi.valid !== 1'b0) begin
            failures++;
            $display("FAIL disc_valid got=%b want=0", if_stage_reg.rvfi.valid);
        end
        tick(1'b0, '0, 2'b00, 1'b0, 1'b0, 1'b0, "disc_wait1");
        tick(1'b0, '0, 2'b00, 1'b0, 1'b0, 1'b0, "disc_wait2");
        tick(1'b0, '0, 2'b00, 1'b1, 1'b1, 1'b1, "disc_resp");
        checks++;
        if (if_stage_reg.pc !== 32'h1eceb200 || if_stage_reg.rvfi.valid !== 1'b1) begin
            failures++;
            $display("FAIL disc_reg got pc=%h valid=%b want pc=1eceb200 valid=1",
                     if_stage_reg.pc, if_stage_reg.rvfi.valid);
        end
        tick(1'b0, '0, 2'b00, 1'b1, 1'b1, 1'b0, "disc_next");
        end_queue("disc_queue");
    endtask

    task automatic test_double_redirect();
        apply_reset();
        exp_q.push_back(RST_PC);
        exp_q.push_back(RST_PC + 32'd4);
        exp_q.push_back(32'h1eceb400);
        exp_q.push_back(32'h1eceb404);
        tick(1'b0, '0, 2'b00, 1'b0, 1'b1, 1'b0, "dbl_c0");
        tick(1'b0, '0, 2'b00, 1'b1, 1'b1, 1'b0, "dbl_c1");
        tick(1'b1, 32'h1eceb300, 2'b00, 1'b0, 1'b0, 1'b0, "dbl_redir1");
        tick(1'b1, 32'h1eceb400, 2'b00, 1'b0, 1'b0, 1'b0, "dbl_redir2");
        tick(1'b0, '0, 2'b00, 1'b1, 1'b1, 1'b1, "dbl_resp");
        tick(1'b0, '0, 2'b00, 1'b1, 1'b1, 1'b0, "dbl_next");
        end_queue("dbl_queue");
    endtask

    task automatic test_misaligned();
        apply_reset();
        exp_q.push_back(RST_PC);
        tick(1'b0, '0, 2'b00, 1'b0, 1'b1, 1'b0, "mis_c0");
`ifdef IF_MISALIGN_TRAP_EN
        tick(1'b1, 32'h1eceb102, 2'b00, 1'b1, 1'b0, 1'b0, "mis_redirect");
        checks++;
        if (o_misaligned !== 1'b1) begin
            failures++;
            $display("FAIL mis_flag got=%b want=1", o_misaligned);
        end
        tick(1'b0, '0, 2'b00, 1'b0, 1'b0, 1'b0, "mis_halt1");
        tick(1'b0, '0, 2'b00, 1'b1, 1'b0, 1'b0, "mis_halt2");
        checks++;
        if (o_misaligned !== 1'b1) begin
            failures++;
            $display("FAIL mis_sticky got=%b want=1", o_misaligned);
        end
`else
        exp_q.push_back(32'h1eceb100);
        exp_q.push_back(32'h1eceb104);
        tick(1'b1, 32'h1eceb102, 2'b00, 1'b1, 1'b1, 1'b0, "mis_redirect");
        checks++;
        if (if_stage_reg.pc !== 32'h1eceb100) begin
            failures++;
            $display("FAIL mis_reg got=%h want=1eceb100", if_stage_reg.pc);
        end
        tick(1'b0, '0, 2'b00, 1'b1, 1'b1, 1'b0, "mis_next");
`endif
        end_queue("mis_queue");
    endtask

    task automatic test_wrap();
        apply_reset();
        exp_q.push_back(RST_PC);
        exp_q.push_back(32'hFFFFFFFC);
        exp_q.push_back(32'h00000000);
        tick(1'b0, '0, 2'b00, 1'b0, 1'b1, 1'b0, "wrap_c0");
        tick(1'b1, 32'hFFFFFFFC, 2'b00, 1'b1, 1'b1, 1'b0, "wrap_redirect");
        checks++;
        if (if_stage_reg.pc_next !== 32'h0 || if_stage_reg.rvfi.pc_wdata !== 32'h0) begin
            failures++;
            $display("FAIL wrap_next got next=%h wdata=%h want 0 0",
                     if_stage_reg.pc_next, if_stage_reg.rvfi.pc_wdata);
        end
        tick(1'b0, '0, 2'b00, 1'b1, 1'b1, 1'b0, "wrap_issue");
        end_queue("wrap_queue");
    endtask

    task automatic test_reset_mid();
        apply_reset();
        exp_q.push_back(RST_PC);
        tick(1'b0, '0, 2'b00, 1'b0, 1'b1, 1'b0, "rmid_c0");
        apply_reset();
        exp_q.push_back(RST_PC);
        exp_q.push_back(RST_PC + 32'd4);
        tick(1'b0, '0, 2'b00, 1'b1, 1'b1, 1'b0, "rmid_late_resp");
        tick(1'b0, '0, 2'b00, 1'b1, 1'b1, 1'b0, "rmid_next");
        end_queue("rmid_queue");
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_stall();
        test_redirect_resp();
        test_discard();
        test_double_redirect();
        test_misaligned();
        test_wrap();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
